sram_bus_arbiter: RTL and testbench

- Sequences the IF-stage fetch stream and the MEM-stage load/store stream onto one shared sram-like bus.
- Raises per-stage stall requests to the stall controller while a stage's access is pending.
- Discards instruction responses that belong to a flushed fetch.
- Sits between the PC/IC fetch pipeline, the MEM stage and the external memory bridge. Only one bus transaction is outstanding at a time.

---
 rtl/sram_bus_arbiter.sv | 170 +++++++++++++++++
 tb/tb_sram_bus_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one sram-like bus between the fetch stream and the
// MEM-stage load/store stream. One transaction outstanding at a time; grants
// are only decided in IDLE, alternating priority when both stages request.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no transaction; arbitrate and latch the winning request
// I_ADDR | fetch address on the bus, waiting for bus_addr_ok
// I_WAIT | fetch accepted by the bus, waiting for bus_data_ok
// D_ADDR | load/store address on the bus, waiting for bus_addr_ok
// D_WAIT | load/store accepted by the bus, waiting for bus_data_ok
module sram_bus_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              inst_req,
   input  logic [ADDR_W-1:0] inst_addr,
   output logic              inst_addr_ok,
   output logic              inst_data_ok,
   output logic [DATA_W-1:0] inst_rdata,
   input  logic              data_req,
   input  logic              data_wr,
   input  logic [1:0]        data_size,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic              data_addr_ok,
   output logic              data_data_ok,
   output logic [DATA_W-1:0] data_rdata,
   output logic              bus_req,
   output logic              bus_wr,
   output logic [1:0]        bus_size,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic              bus_addr_ok,
   input  logic              bus_data_ok,
   input  logic [DATA_W-1:0] bus_rdata,
   output logic              stallreq_if,
   output logic              stallreq_mem
);

   typedef enum logic [2:0] {IDLE, I_ADDR, I_WAIT, D_ADDR, D_WAIT} state_t;

   state_t            state_q, state_d;
   logic              last_data_q;   // 1 = data owned the bus last
   logic              discard_q;
   logic              inst_busy_q, data_busy_q;
   logic              lat_wr_q;
   logic [1:0]        lat_size_q;
   logic [ADDR_W-1:0] lat_addr_q;
   logic [DATA_W-1:0] lat_wdata_q;
   logic [DATA_W-1:0] inst_rdata_q, data_rdata_q;
   logic              inst_dok_q, data_dok_q;

   logic grant_i, grant_d;
   logic complete_i, complete_d;
   logic drop_i;

   // arbitration and completion detection
   always_comb begin
      grant_d    = 1'b0;
      grant_i    = 1'b0;
      complete_i = 1'b0;
      complete_d = 1'b0;
      if (!rst && state_q == IDLE) begin
         grant_d = data_req & (~inst_req | ~last_data_q);
         grant_i = inst_req & ~grant_d;
      end
      if ((state_q == I_ADDR && bus_addr_ok) || state_q == I_WAIT)
         complete_i = bus_data_ok;
      if ((state_q == D_ADDR && bus_addr_ok) || state_q == D_WAIT)
         complete_d = bus_data_ok;
   end

   // a flush arriving in the completion cycle still kills that fetch
   assign drop_i = discard_q | flush;

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (grant_d)      state_d = D_ADDR;
            else if (grant_i) state_d = I_ADDR;
         end
         I_ADDR: begin
            if (complete_i)       state_d = IDLE;
            else if (bus_addr_ok) state_d = I_WAIT;
         end
         I_WAIT: if (complete_i) state_d = IDLE;
         D_ADDR: begin
            if (complete_d)       state_d = IDLE;
            else if (bus_addr_ok) state_d = D_WAIT;
         end
         D_WAIT: if (complete_d) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // state, request latches, busy/discard flags and response capture
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_data_q  <= 1'b0;
         discard_q    <= 1'b0;
         inst_busy_q  <= 1'b0;
         data_busy_q  <= 1'b0;
         lat_wr_q     <= 1'b0;
         lat_size_q   <= 2'd0;
         lat_addr_q   <= '0;
         lat_wdata_q  <= '0;
         inst_rdata_q <= '0;
         data_rdata_q <= '0;
         inst_dok_q   <= 1'b0;
         data_dok_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         inst_dok_q <= complete_i & ~drop_i;
         data_dok_q <= complete_d;
         if (grant_d) begin
            lat_wr_q    <= data_wr;
            lat_size_q  <= data_size;
            lat_addr_q  <= data_addr;
            lat_wdata_q <= data_wdata;
            data_busy_q <= 1'b1;
            last_data_q <= 1'b1;
         end else if (grant_i) begin
            lat_wr_q    <= 1'b0;
            lat_size_q  <= 2'd2;
            lat_addr_q  <= inst_addr;
            lat_wdata_q <= '0;
            inst_busy_q <= 1'b1;
            last_data_q <= 1'b0;
         end
         if (complete_d) begin
            data_busy_q  <= 1'b0;
            data_rdata_q <= bus_rdata;
         end
         if (complete_i) begin
            inst_busy_q <= 1'b0;
            discard_q   <= 1'b0;
            if (!drop_i) inst_rdata_q <= bus_rdata;
         end else if (flush && (grant_i || state_q == I_ADDR || state_q == I_WAIT)) begin
            discard_q <= 1'b1;
         end
      end
   end

   // bus side and stage handshakes
   always_comb begin
      inst_addr_ok = grant_i;
      data_addr_ok = grant_d;
      inst_data_ok = inst_dok_q;
      data_data_ok = data_dok_q;
      inst_rdata   = inst_rdata_q;
      data_rdata   = data_rdata_q;
      bus_req      = (state_q == I_ADDR) || (state_q == D_ADDR);
      bus_wr       = lat_wr_q;
      bus_size     = lat_size_q;
      bus_addr     = lat_addr_q;
      bus_wdata    = lat_wdata_q;
      stallreq_if  = ~rst & ~inst_dok_q &
                     ((inst_req & ~grant_i) | (inst_busy_q & ~discard_q));
      stallreq_mem = ~rst & ~data_dok_q &
                     ((data_req & ~grant_d) | data_busy_q);
   end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter: a per-cycle vector table plus
// hand-written sequences for the slow bus, store fields and mid-transaction reset.
module tb_sram_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst, flush;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok, inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr, data_wdata;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;
   logic        bus_req, bus_wr;
   logic [1:0]  bus_size;
   logic [31:0] bus_addr, bus_wdata;
   logic        bus_addr_ok, bus_data_ok;
   logic [31:0] bus_rdata;
   logic        stallreq_if, stallreq_mem;

   int checks = 0;
   int failures = 0;

   // {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, bus_req, stallreq_if, stallreq_mem}
   logic [6:0] outv;
   assign outv = {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok,
                  bus_req, stallreq_if, stallreq_mem};

   always #5 clk = ~clk;

   sram_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .inst_req(inst_req), .inst_addr(inst_addr),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
      .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem)
   );

   typedef struct {
      string       name;
      logic        rst, flush, ireq;
      logic [31:0] ia;
      logic        dreq;
      logic [31:0] da;
      logic        baok, bdok;
      logic [31:0] brd;
      logic [6:0]  exp;
      logic [31:0] ea;   // expected bus_addr when bus_req expected
      logic [31:0] er;   // expected rdata when a data_ok is expected
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(string n, logic r, logic f, logic ir, logic [31:0] ia,
                              logic dr, logic [31:0] da, logic ao, logic dok,
                              logic [31:0] brd, logic [6:0] e, logic [31:0] ea,
                              logic [31:0] er);
      vec_t x;
      x.name = n; x.rst = r; x.flush = f; x.ireq = ir; x.ia = ia;
      x.dreq = dr; x.da = da; x.baok = ao; x.bdok = dok; x.brd = brd;
      x.exp = e; x.ea = ea; x.er = er;
      return x;
   endfunction

   task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", n, act, exp);
      end
   endtask

   task automatic zero_inputs();
      rst = 1'b0; flush = 1'b0;
      inst_req = 1'b0; inst_addr = '0;
      data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2;
      data_addr = '0; data_wdata = '0;
      bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
   endtask

   initial begin
      zero_inputs();
      rst = 1'b1;
      repeat (2) @(negedge clk);

      tbl.push_back(v("rst_idle",0,0,0,0,0,0,0,0,0,7'b0000000,0,0));
      // lone fetch
      tbl.push_back(v("lone_c0",0,0,1,32'hBFC00000,0,0,0,0,0,7'b1000000,0,0));
      tbl.push_back(v("lone_c1",0,0,0,0,0,0,1,0,0,7'b0000110,32'hBFC00000,0));
      tbl.push_back(v("lone_c2",0,0,0,0,0,0,0,1,32'h3C1D0000,7'b0000010,0,0));
      tbl.push_back(v("lone_c3",0,0,0,0,0,0,0,0,0,7'b0100000,0,32'h3C1D0000));
      tbl.push_back(v("re_rst",1,0,0,0,0,0,0,0,0,7'b0000000,0,0));
      // simultaneous requests: data first, then inst, then data again
      tbl.push_back(v("both_c0",0,0,1,32'h80000000,1,32'h80001000,0,0,0,7'b0010010,0,0));
      tbl.push_back(v("both_c1",0,0,1,32'h80000000,0,0,1,0,0,7'b0000111,32'h80001000,0));
      tbl.push_back(v("both_c2",0,0,1,32'h80000000,0,0,0,1,32'h12345678,7'b0000011,0,0));
      tbl.push_back(v("both_c3",0,0,1,32'h80000000,1,32'h80002000,0,0,0,7'b1001000,0,32'h12345678));
      tbl.push_back(v("both_c4",0,0,0,0,1,32'h80002000,1,0,0,7'b0000111,32'h80000000,0));
      tbl.push_back(v("both_c5",0,0,0,0,1,32'h80002000,0,1,32'hCAFEF00D,7'b0000011,0,0));
      tbl.push_back(v("both_c6",0,0,0,0,1,32'h80002000,0,0,0,7'b0110000,0,32'hCAFEF00D));
      tbl.push_back(v("both_c7",0,0,0,0,0,0,1,1,32'h55AA55AA,7'b0000101,32'h80002000,0));
      tbl.push_back(v("both_c8",0,0,0,0,0,0,0,0,0,7'b0001000,0,32'h55AA55AA));
      // flush in I_WAIT
      tbl.push_back(v("fl_c0",0,0,1,32'h00001000,0,0,0,0,0,7'b1000000,0,0));
      tbl.push_back(v("fl_c1",0,0,0,0,0,0,1,0,0,7'b0000110,32'h00001000,0));
      tbl.push_back(v("fl_c2",0,1,0,0,0,0,0,0,0,7'b0000010,0,0));
      tbl.push_back(v("fl_c3",0,0,0,0,0,0,0,0,0,7'b0000000,0,0));
      tbl.push_back(v("fl_c4",0,0,0,0,0,0,0,1,32'hDEADBEEF,7'b0000000,0,0));
      tbl.push_back(v("fl_c5",0,0,1,32'h00002000,0,0,0,0,0,7'b1000000,0,0));
      tbl.push_back(v("fl_c6",0,0,0,0,0,0,1,0,0,7'b0000110,32'h00002000,0));
      tbl.push_back(v("fl_c7",0,0,0,0,0,0,0,1,32'h600DF00D,7'b0000010,0,0));
      tbl.push_back(v("fl_c8",0,0,0,0,0,0,0,0,0,7'b0100000,0,32'h600DF00D));
      // flush in the inst grant cycle
      tbl.push_back(v("gf_c0",0,1,1,32'h00003000,0,0,0,0,0,7'b1000000,0,0));
      tbl.push_back(v("gf_c1",0,0,0,0,0,0,1,0,0,7'b0000100,32'h00003000,0));
      tbl.push_back(v("gf_c2",0,0,0,0,0,0,0,1,32'h77777777,7'b0000000,0,0));
      tbl.push_back(v("gf_c3",0,0,0,0,0,0,0,0,0,7'b0000000,0,0));
      // flush does not touch a data transaction
      tbl.push_back(v("df_c0",0,1,0,0,1,32'h00004000,0,0,0,7'b0010000,0,0));
      tbl.push_back(v("df_c1",0,1,0,0,0,0,1,1,32'h0BADCAFE,7'b0000101,32'h00004000,0));
      tbl.push_back(v("df_c2",0,0,0,0,0,0,0,0,0,7'b0001000,0,32'h0BADCAFE));

      foreach (tbl[i]) begin
         rst = tbl[i].rst; flush = tbl[i].flush;
         inst_req = tbl[i].ireq; inst_addr = tbl[i].ia;
         data_req = tbl[i].dreq; data_addr = tbl[i].da;
         data_wr = 1'b0; data_size = 2'd2; data_wdata = '0;
         bus_addr_ok = tbl[i].baok; bus_data_ok = tbl[i].bdok; bus_rdata = tbl[i].brd;
         #1;
         chk({tbl[i].name, " ctl"}, 32'(outv), 32'(tbl[i].exp));
         if (tbl[i].exp[2]) chk({tbl[i].name, " bus_addr"}, bus_addr, tbl[i].ea);
         if (tbl[i].exp[5]) chk({tbl[i].name, " inst_rdata"}, inst_rdata, tbl[i].er);
         if (tbl[i].exp[3]) chk({tbl[i].name, " data_rdata"}, data_rdata, tbl[i].er);
         @(negedge clk);
      end
      zero_inputs();

      // slow bus on a fetch, with a store raised while the fetch is outstanding
      inst_req = 1'b1; inst_addr = 32'h90000040;
      #1 chk("slow grant", 32'(inst_addr_ok), 32'd1);
      @(negedge clk);
      inst_req = 1'b0;
      for (int k = 0; k < 5; k++) begin
         data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0;
         data_addr = 32'h80000003; data_wdata = 32'h000000AB;
         bus_addr_ok = 1'b0;
         #1;
         chk("slow bus_req", 32'(bus_req), 32'd1);
         chk("slow bus_addr", bus_addr, 32'h90000040);
         chk("slow bus_wr/size", 32'({bus_wr, bus_size}), 32'({1'b0, 2'd2}));
         chk("slow no data_addr_ok", 32'(data_addr_ok), 32'd0);
         chk("slow stallreq_mem", 32'(stallreq_mem), 32'd1);
         @(negedge clk);
      end
      bus_addr_ok = 1'b1;
      #1 chk("slow addr_ok ctl", 32'(outv), 32'(7'b0000111));
      @(negedge clk);
      bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h11112222;
      #1 chk("slow wait ctl", 32'(outv), 32'(7'b0000011));
      @(negedge clk);
      bus_data_ok = 1'b0; bus_rdata = '0;
      #1;
      chk("slow done ctl", 32'(outv), 32'(7'b0110000));
      chk("slow inst_rdata", inst_rdata, 32'h11112222);
      @(negedge clk);
      data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2; data_addr = '0; data_wdata = '0;
      for (int k = 0; k < 4; k++) begin
         bus_addr_ok = (k == 3);
         #1;
         chk("store bus_req", 32'(bus_req), 32'd1);
         chk("store bus_wr/size", 32'({bus_wr, bus_size}), 32'({1'b1, 2'd0}));
         chk("store bus_addr", bus_addr, 32'h80000003);
         chk("store bus_wdata", bus_wdata, 32'h000000AB);
         chk("store stallreq_mem", 32'(stallreq_mem), 32'd1);
         @(negedge clk);
      end
      bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
      #1 chk("store data_ok early", 32'(data_data_ok), 32'd0);
      @(negedge clk);
      bus_data_ok = 1'b0;
      #1 chk("store done ctl", 32'(outv), 32'(7'b0001000));
      @(negedge clk);

      // reset in D_WAIT, then a stray bus_data_ok
      data_req = 1'b1; data_addr = 32'h00000044; data_wdata = 32'h5A5A5A5A;
      #1 chk("rstw grant", 32'(data_addr_ok), 32'd1);
      @(negedge clk);
      data_req = 1'b0; bus_addr_ok = 1'b1;
      #1 chk("rstw bus_req", 32'(bus_req), 32'd1);
      @(negedge clk);
      bus_addr_ok = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rstw ctl", 32'(outv), 32'd0);
      chk("rstw bus fields", 32'({bus_wr, bus_size}), 32'd0);
      chk("rstw bus_addr", bus_addr, 32'd0);
      chk("rstw bus_wdata", bus_wdata, 32'd0);
      chk("rstw inst_rdata", inst_rdata, 32'd0);
      chk("rstw data_rdata", data_rdata, 32'd0);
      bus_data_ok = 1'b1; bus_rdata = 32'hFFFF0000;
      @(negedge clk);
      bus_data_ok = 1'b0;
      #1;
      chk("stray ctl", 32'(outv), 32'd0);
      chk("stray data_rdata", data_rdata, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
